mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage fed by the EX/MEM register. Non-memory ops pass straight through to MEM/WB.
//  Loads and stores run as byte-serial transfers on the 8-bit memory-controller port; mem_stall_o
//  holds EX/MEM and earlier stages until the transfer finishes. Loads are sign/zero-extended here.
// PARAMETERS
//  ADDR_W   32  byte-address width
//  DATA_W   32  register data width; transfers are 1, 2 or 4 bytes of DATA_W
// PORTS
//  clk          in   1       clock; all state updates on the rising edge
//  rst          in   1       asynchronous, active-high reset
//  rdy          in   1       global enable; when 0 all state and outputs hold
//  rd_data_i    in   DATA_W  ALU result (non-mem ops) or store data
//  rd_addr_i    in   5       destination register address
//  addr_i       in   ADDR_W  effective memory address
//  op_i         in   `OpLen  operation code (`LB,`LH,`LW,`LBU,`LHU,`SB,`SH,`SW, other)
//  mc_req_o     out  1       byte request to memory controller
//  mc_we_o      out  1       1 = write byte, 0 = read byte
//  mc_addr_o    out  ADDR_W  byte address = addr_i + byte index k
//  mc_wdata_o   out  8       rd_data_i[8k+7:8k]
//  mc_ack_i     in   1       one-cycle pulse: current byte done
//  mc_rdata_i   in   8       read byte, valid in the mc_ack_i cycle
//  mem_stall_o  out  1       hold upstream stages (to EX/MEM register stall input)
//  wb_rd_data_o out  DATA_W  result to MEM/WB
//  wb_rd_addr_o out  5       destination to MEM/WB; 0 for stores
//  misalign_o   out  1       misaligned access flag (MEM_MISALIGN_TRAP_EN only; else tied 0)
// BEHAVIOUR
//  - States IDLE, ACCESS, DONE. Byte counter k (0..3), byte count N = 1/2/4 from op_i.
//  - Reset (async): state IDLE, k 0, load buffer 0, mc_req_o 0, mc_we_o 0, mc_addr_o 0,
//    mc_wdata_o 0, mem_stall_o 0, wb_rd_data_o 0, wb_rd_addr_o 0, misalign_o 0.
//    Reset mid-transfer aborts it; no further requests; partial store bytes are not undone.
//  - IDLE, non-mem op: wb_rd_data_o=rd_data_i, wb_rd_addr_o=rd_addr_i combinationally, stall 0.
//  - IDLE, mem op: mem_stall_o=1 combinationally same cycle; mc_req_o=1 for byte 0; -> ACCESS.
//  - ACCESS: mc_req_o=1, stall 1. On mc_ack_i (sampled only when rdy=1): read -> buffer byte k
//    = mc_rdata_i; if k==N-1 -> DONE, else k+1 and request next byte next cycle (req stays high).
//  - Latency: N acks + 1 cycle. Minimum (ack every cycle) 1-byte op: stall for 2 cycles.
//  - DONE: mc_req_o=0, mem_stall_o=0; wb outputs from registered result; next edge -> IDLE, k=0.
//    EX/MEM advances on that same edge, so one op is never issued twice.
//  - Extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW uses 4 bytes little-endian.
//  - Stores: wb_rd_addr_o=0, wb_rd_data_o=0 throughout; writes bytes little-endian at addr_i+k.
//  - mc_addr_o = addr_i + k, ADDR_W wrap-around (0xFFFFFFFF + 1 -> 0x0).
//  - rdy=0: state, k, buffer frozen; mc_req_o keeps its value; acks ignored.
//  - mc_ack_i outside ACCESS is ignored.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr_i[0]=1, or LW/SW with addr_i[1:0]!=0,
//    -> no mc request, state stays IDLE, stall 0, misalign_o=1 (combinational, this op only),
//    wb_rd_addr_o=0 (no writeback).
//  Not defined: misaligned accesses run as normal byte-serial transfers; misalign_o tied 0.
// TESTING
//  1. op=ADD, rd_data_i=0x1234, rd_addr_i=5 -> same cycle wb 0x1234/5, stall 0, no mc_req_o.
//  2. LB addr=0x100, ack next cycle with rdata 0x80 -> stall 2 cycles, wb=0xFFFFFF80; LBU -> 0x80.
//  3. SW addr=0x200 data=0xA1B2C3D4, ack each cycle -> writes D4,C3,B2,A1 at 0x200..0x203,
//     wb_rd_addr_o=0, stall drops in DONE after 4th ack.
//  4. LW, rdy=0 for 3 cycles mid-transfer with ack pulses -> those acks ignored, final value correct.
//  5. rst pulsed between byte 1 and 2 of LW -> immediate IDLE, mc_req_o 0, all outputs 0.
//  6. MEM_MISALIGN_TRAP_EN, LW addr=0x102 -> misalign_o=1, no mc_req_o; undefined -> 4-byte transfer.

Source files
------------

// File: rtl/mem_stage_if.sv
// Memory-controller byte bus between the MEM stage (master) and the controller (slave).
// Also provides the shared operation-code macros (`OpLen, `LB ... `SW) used by mem_stage.

`ifndef MEM_STAGE_OPS
`define MEM_STAGE_OPS
`define OpLen 4
`define OP_NOP 4'd0
`define LB     4'd1
`define LH     4'd2
`define LW     4'd3
`define LBU    4'd4
`define LHU    4'd5
`define SB     4'd6
`define SH     4'd7
`define SW     4'd8
`endif

interface mem_stage_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mc_req;
    logic              mc_we;
    logic [ADDR_W-1:0] mc_addr;
    logic [7:0]        mc_wdata;
    logic              mc_ack;
    logic [7:0]        mc_rdata;

    modport master (
        output mc_req,
        output mc_we,
        output mc_addr,
        output mc_wdata,
        input  mc_ack,
        input  mc_rdata
    );

    modport slave (
        input  mc_req,
        input  mc_we,
        input  mc_addr,
        input  mc_wdata,
        output mc_ack,
        output mc_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: non-memory ops pass through to MEM/WB; loads/stores are run as
// little-endian byte-serial transfers on the memory-controller port while stalling upstream.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (flag misaligned half/word accesses instead of
// performing them).

module mem_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [`OpLen-1:0] op_i,
    mem_stage_if.master       mc,
    output logic              mem_stall_o,
    output logic [DATA_W-1:0] wb_rd_data_o,
    output logic [4:0]        wb_rd_addr_o,
    output logic              misalign_o
);

    localparam int unsigned BUF_W = 32;
    localparam int unsigned OP_W  = `OpLen;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_k;
    logic [1:0]         w_k_nxt;
    logic [1:0]         w_k_inc;
    logic               w_last;
    logic               w_start;

    // Decoded view of the incoming op
    logic               w_is_load;
    logic               w_is_store;
    logic [2:0]         w_nbytes;
    logic               w_misalign;

    // Transfer context captured when the access starts
    logic [OP_W-1:0]    r_op;
    logic [ADDR_W-1:0]  r_base;
    logic [DATA_W-1:0]  r_sdata;
    logic [4:0]         r_rd_addr;
    logic [2:0]         r_nbytes;
    logic               r_is_store;
    logic [BUF_W-1:0]   r_buf;
    logic [DATA_W-1:0]  w_result;

    // Registered controller-side outputs
    logic               r_mc_req;
    logic               r_mc_we;
    logic [ADDR_W-1:0]  r_mc_addr;
    logic [7:0]         r_mc_wdata;

    assign mc.mc_req   = r_mc_req;
    assign mc.mc_we    = r_mc_we;
    assign mc.mc_addr  = r_mc_addr;
    assign mc.mc_wdata = r_mc_wdata;

    assign w_k_inc = r_k + 2'd1;
    assign w_last  = ({1'b0, r_k} + 3'd1) == r_nbytes;

    // Classify op_i into load/store and its byte count
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_nbytes   = 3'd0;
        case (op_i)
            `LB, `LBU: begin w_is_load  = 1'b1; w_nbytes = 3'd1; end
            `LH, `LHU: begin w_is_load  = 1'b1; w_nbytes = 3'd2; end
            `LW:       begin w_is_load  = 1'b1; w_nbytes = 3'd4; end
            `SB:       begin w_is_store = 1'b1; w_nbytes = 3'd1; end
            `SH:       begin w_is_store = 1'b1; w_nbytes = 3'd2; end
            `SW:       begin w_is_store = 1'b1; w_nbytes = 3'd4; end
            default:   begin w_is_load  = 1'b0; end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Half-words need an even address, words a 4-byte aligned one
    assign w_misalign = ((w_nbytes == 3'd2) && addr_i[0]) ||
                        ((w_nbytes == 3'd4) && (addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Sign/zero-extend the assembled load bytes according to the captured op
    always_comb begin
        w_result = '0;
        case (r_op)
            `LB:     w_result = {{(DATA_W-8){r_buf[7]}}, r_buf[7:0]};
            `LH:     w_result = {{(DATA_W-16){r_buf[15]}}, r_buf[15:0]};
            `LBU:    w_result = DATA_W'(r_buf[7:0]);
            `LHU:    w_result = DATA_W'(r_buf[15:0]);
            `LW:     w_result = DATA_W'(r_buf);
            default: w_result = '0;
        endcase
    end

    // State register; everything freezes while rdy is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= 2'd0;
        end else if (rdy) begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Next-state and combinational outputs; reset forces every output low
    always_comb begin
        w_state_nxt  = r_state;
        w_k_nxt      = r_k;
        w_start      = 1'b0;
        mem_stall_o  = 1'b0;
        wb_rd_data_o = '0;
        wb_rd_addr_o = 5'd0;
        misalign_o   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_k_nxt = 2'd0;
                if (w_is_load || w_is_store) begin
                    if (w_misalign) begin
                        misalign_o = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        mem_stall_o = 1'b1;
                        w_state_nxt = S_ACCESS;
                    end
                end else begin
                    wb_rd_data_o = rd_data_i;
                    wb_rd_addr_o = rd_addr_i;
                end
            end
            S_ACCESS: begin
                mem_stall_o = 1'b1;
                if (mc.mc_ack) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_k_nxt = w_k_inc;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = 2'd0;
                if (!r_is_store) begin
                    wb_rd_data_o = w_result;
                    wb_rd_addr_o = r_rd_addr;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = 2'd0;
            end
        endcase
        if (rst) begin
            mem_stall_o  = 1'b0;
            wb_rd_data_o = '0;
            wb_rd_addr_o = 5'd0;
            misalign_o   = 1'b0;
        end
    end

    // Transfer context, load buffer and the byte request driven to the controller
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= '0;
            r_base     <= '0;
            r_sdata    <= '0;
            r_rd_addr  <= 5'd0;
            r_nbytes   <= 3'd0;
            r_is_store <= 1'b0;
            r_buf      <= '0;
            r_mc_req   <= 1'b0;
            r_mc_we    <= 1'b0;
            r_mc_addr  <= '0;
            r_mc_wdata <= 8'd0;
        end else if (rdy) begin
            if (w_start) begin
                r_op       <= op_i;
                r_base     <= addr_i;
                r_sdata    <= rd_data_i;
                r_rd_addr  <= w_is_store ? 5'd0 : rd_addr_i;
                r_nbytes   <= w_nbytes;
                r_is_store <= w_is_store;
                r_mc_req   <= 1'b1;
                r_mc_we    <= w_is_store;
                r_mc_addr  <= addr_i;
                r_mc_wdata <= rd_data_i[7:0];
            end else if ((r_state == S_ACCESS) && mc.mc_ack) begin
                if (!r_is_store) begin
                    r_buf[{r_k, 3'b000} +: 8] <= mc.mc_rdata;
                end
                if (w_last) begin
                    r_mc_req <= 1'b0;
                    r_mc_we  <= 1'b0;
                end else begin
                    r_mc_addr  <= r_base + ADDR_W'(w_k_inc);
                    r_mc_wdata <= r_sdata[{w_k_inc, 3'b000} +: 8];
                end
            end
        end
    end

endmodule
